// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with phase FSMs, sync outputs delayed
// one cycle to line up with downstream registered RGB, plus line/frame strobes.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    // state       | meaning
    // *_ST_ACT    | visible pixels / lines
    // *_ST_FP     | front porch
    // *_ST_SYNC   | sync pulse
    // *_ST_BP     | back porch
    localparam logic [1:0] H_ST_ACT  = 2'd0;
    localparam logic [1:0] H_ST_FP   = 2'd1;
    localparam logic [1:0] H_ST_SYNC = 2'd2;
    localparam logic [1:0] H_ST_BP   = 2'd3;
    localparam logic [1:0] V_ST_ACT  = 2'd0;
    localparam logic [1:0] V_ST_FP   = 2'd1;
    localparam logic [1:0] V_ST_SYNC = 2'd2;
    localparam logic [1:0] V_ST_BP   = 2'd3;

    // Last count of each phase; a phase is left on the edge where its counter holds this value.
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [1:0] h_state_q, h_state_d;
    logic [1:0] v_state_q, v_state_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       h_wrap;
    logic       v_last;

    always_comb begin
        h_wrap = (hc_q == H_LAST);
        v_last = (vc_q == V_LAST);

        hc_d = h_wrap ? 10'd0 : hc_q + 10'd1;
        vc_d = vc_q;
        if (h_wrap) begin
            vc_d = v_last ? 10'd0 : vc_q + 10'd1;
        end

        h_state_d = h_state_q;
        case (h_state_q)
            H_ST_ACT:  if (hc_q == H_ACT_END)  h_state_d = H_ST_FP;
            H_ST_FP:   if (hc_q == H_FP_END)   h_state_d = H_ST_SYNC;
            H_ST_SYNC: if (hc_q == H_SYNC_END) h_state_d = H_ST_BP;
            H_ST_BP:   if (h_wrap)             h_state_d = H_ST_ACT;
            default:                           h_state_d = H_ST_ACT;
        endcase

        // Vertical phase only moves on a horizontal wrap.
        v_state_d = v_state_q;
        if (h_wrap) begin
            case (v_state_q)
                V_ST_ACT:  if (vc_q == V_ACT_END)  v_state_d = V_ST_FP;
                V_ST_FP:   if (vc_q == V_FP_END)   v_state_d = V_ST_SYNC;
                V_ST_SYNC: if (vc_q == V_SYNC_END) v_state_d = V_ST_BP;
                V_ST_BP:   if (v_last)             v_state_d = V_ST_ACT;
                default:                           v_state_d = V_ST_ACT;
            endcase
        end

        hs_d          = (h_state_q != H_ST_SYNC);
        vs_d          = (v_state_q != V_ST_SYNC);
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_last;
        frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            h_state_q     <= H_ST_ACT;
            v_state_q     <= V_ST_ACT;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = (h_state_q == H_ST_ACT) && (v_state_q == V_ST_ACT);
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so 256 frames fit in a short run;
// outputs are predicted from the elapsed cycle count since reset.
module tb_vga_timing_gen;

    localparam int HA  = 10;
    localparam int HF  = 3;
    localparam int HSW = 4;
    localparam int HB  = 3;
    localparam int VA  = 6;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 2;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FR  = HT * VT;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    int total = 0;
    int bad   = 0;
    int t     = 0;   // cycles since the last reset edge

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .hs         (hs),
        .vs         (vs),
        .line_start (line_start),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp))
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // One clock: advance the reference time, then compare every output at the falling edge.
    task automatic step();
        int hc, vc, phc, pvc;
        bit hs_e, vs_e;
        @(posedge vga_clk);
        if (reset) t = 0;
        else t++;
        @(negedge vga_clk);
        hc  = t % HT;
        vc  = (t / HT) % VT;
        phc = (t + FR - 1) % HT;
        pvc = ((t + FR - 1) / HT) % VT;
        hs_e = (t == 0) ? 1'b1 : !(phc >= HA + HF && phc < HA + HF + HSW);
        vs_e = (t == 0) ? 1'b1 : !(pvc >= VA + VF && pvc < VA + VF + VSW);
        chk("DrawX", 32'(DrawX), hc);
        chk("DrawY", 32'(DrawY), vc);
        chk("blank", 32'(blank), int'(hc < HA && vc < VA));
        chk("hs", 32'(hs), int'(hs_e));
        chk("vs", 32'(vs), int'(vs_e));
        chk("line_start", 32'(line_start), int'(t > 0 && hc == 0));
        chk("frame_start", 32'(frame_start), int'(t > 0 && (t % FR) == 0));
        chk("frame_count", 32'(frame_count), (t / FR) % 256);
    endtask

    initial begin
        int hs_low, hs_first, hs_last, blank_fall, ls_x, ls_y, ls_n;
        int vs_low, vs_fx, vs_fy, vs_lx, vs_ly, fs_t, n, row;
        bit found;

        // Reset held three cycles, then released.
        reset = 1'b1;
        repeat (3) step();
        chk("rst_DrawX", 32'(DrawX), 0);
        chk("rst_hs", 32'(hs), 1);
        chk("rst_blank", 32'(blank), 1);
        reset = 1'b0;
        step();
        chk("first_inc_DrawX", 32'(DrawX), 1);

        // Rest of the first line: blank fall point, hs window, line_start position.
        hs_low = 0; hs_first = -1; hs_last = -1; blank_fall = -1; ls_n = 0; ls_x = -1; ls_y = -1;
        vs_low = 0; vs_fx = -1; vs_fy = -1; vs_lx = -1; vs_ly = -1;
        while (t < HT) begin
            if (!blank && blank_fall < 0) blank_fall = int'(DrawX);
            if (!hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(DrawX);
                hs_last = int'(DrawX);
            end
            step();
            if (line_start) begin
                ls_n++; ls_x = int'(DrawX); ls_y = int'(DrawY);
            end
        end
        chk("blank_fall_x", 32'(blank_fall), HA);
        chk("hs_low_count", 32'(hs_low), HSW);
        chk("hs_first_x", 32'(hs_first), HA + HF + 1);
        chk("hs_last_x", 32'(hs_last), HA + HF + HSW);
        chk("line_start_n", 32'(ls_n), 1);
        chk("line_start_xy", 32'(ls_x * 1000 + ls_y), 1);

        // Remainder of the first frame: vs window and first frame_start timing.
        found = 1'b0; fs_t = -1; n = 0;
        while (!found && n < 2 * FR) begin
            step();
            n++;
            if (!vs) begin
                vs_low++;
                if (vs_fx < 0) begin vs_fx = int'(DrawX); vs_fy = int'(DrawY); end
                vs_lx = int'(DrawX); vs_ly = int'(DrawY);
            end
            if (frame_start) begin found = 1'b1; fs_t = t; end
        end
        chk("fs1_seen", 32'(found), 1);
        chk("fs1_time", 32'(fs_t), FR);
        chk("fs1_count", 32'(frame_count), 1);
        chk("vs_low_count", 32'(vs_low), VSW * HT);
        chk("vs_first_xy", 32'(vs_fy * 1000 + vs_fx), (VA + VF) * 1000 + 1);
        chk("vs_last_xy", 32'(vs_ly * 1000 + vs_lx), (VA + VF + VSW) * 1000);

        // Run to the 256th frame_start, watching the 255 -> 0 wrap.
        for (int k = 2; k <= 256; k++) begin
            found = 1'b0; n = 0;
            while (!found && n < FR + 5) begin
                step();
                n++;
                found = frame_start;
            end
            chk("fs_seen", 32'(found), 1);
            if (k == 255) chk("frame_count_255", 32'(frame_count), 255);
            if (k == 256) chk("frame_count_wrap", 32'(frame_count), 0);
        end

        // Reset for a single cycle in the middle of an hsync pulse.
        row = int'($urandom_range(1, VT - 1));
        found = 1'b0; n = 0;
        while (!found && n < FR + 5) begin
            step();
            n++;
            found = (int'(DrawX) == HA + HF + 2) && (int'(DrawY) == row);
        end
        chk("mid_sync_reached", 32'(found), 1);
        chk("mid_sync_hs_low", 32'(hs), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_hs", 32'(hs), 1);
        chk("mid_rst_xy", 32'(int'(DrawY) * 1000 + int'(DrawX)), 0);
        chk("mid_rst_fc", 32'(frame_count), 0);
        found = 1'b0; n = 0;
        while (!found && n < HT + 5) begin
            step();
            n++;
            found = !hs;
        end
        chk("resume_hs_seen", 32'(found), 1);
        chk("resume_hs_x", 32'(DrawX), HA + HF + 1);

        // Random-length runs broken by random-length reset pulses.
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(1, 3 * FR)) step();
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            reset = 1'b0;
        end
        repeat (2 * FR) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
